// File: rtl/ucie_link_stats_collector.sv
// ---------------------------------------------------------------------------
// ucie_link_stats_collector
//
// Purpose:
//   Observes the D2D/PHY datapath (TX/RX flit handshakes, end-of-packet
//   markers, error strobes, link-up) and produces the registered status
//   values consumed directly by the controller/device status fields:
//     - cumulative, saturating 32-bit counters (uptime, packets, errors)
//     - windowed metrics (bandwidth utilization, link quality) published
//       once per 2^WINDOW_LOG2-cycle measurement window.
//
// Parameters:
//   WINDOW_LOG2    window length is 2^WINDOW_LOG2 cycles (legal 4..20)
//   UNCORR_WEIGHT  quality penalty per uncorrectable error
//
// Ports:
//   clk                      in   single clock
//   rst_n                    in   asynchronous active-low reset
//   link_up_in               in   link operational (from LTSM)
//   tx_valid/tx_ready/tx_eop in   TX flit handshake + end-of-packet
//   rx_valid/rx_ready/rx_eop in   RX flit handshake + end-of-packet
//   err_corr                 in   one correctable error this cycle
//   err_uncorr               in   one uncorrectable error this cycle
//   stats_clear              in   clears the four packet/error counters
//   link_up                  out  link_up_in delayed one cycle
//   link_uptime              out  consecutive cycles with link up
//   packet_count_tx/rx       out  completed packets
//   error_count_total        out  correctable + uncorrectable errors
//   error_count_correctable  out  correctable errors
//   bandwidth_utilization    out  active cycles in last completed window
//   link_quality             out  255 - min(error weight, 255), 0 = unknown
//   stats_valid              out  windowed metrics valid
// ---------------------------------------------------------------------------
module ucie_link_stats_collector #(
    parameter int WINDOW_LOG2   = 10,
    parameter int UNCORR_WEIGHT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        link_up_in,
    input  logic        tx_valid,
    input  logic        tx_ready,
    input  logic        tx_eop,
    input  logic        rx_valid,
    input  logic        rx_ready,
    input  logic        rx_eop,
    input  logic        err_corr,
    input  logic        err_uncorr,
    input  logic        stats_clear,
    output logic        link_up,
    output logic [31:0] link_uptime,
    output logic [31:0] packet_count_tx,
    output logic [31:0] packet_count_rx,
    output logic [31:0] error_count_total,
    output logic [31:0] error_count_correctable,
    output logic [31:0] bandwidth_utilization,
    output logic [7:0]  link_quality,
    output logic        stats_valid
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [WINDOW_LOG2-1:0] CNT_ZERO   = {WINDOW_LOG2{1'b0}};
    localparam logic [WINDOW_LOG2-1:0] CNT_ONE    = {{(WINDOW_LOG2-1){1'b0}}, 1'b1};
    localparam logic [WINDOW_LOG2-1:0] CNT_LAST   = {WINDOW_LOG2{1'b1}};
    localparam logic [16:0]            UNCORR_INC = UNCORR_WEIGHT[16:0];

    // -----------------------------------------------------------------------
    // Event decode
    // -----------------------------------------------------------------------
    logic       tx_beat;
    logic       rx_beat;
    logic       tx_pkt;
    logic       rx_pkt;
    logic       active_cycle;
    logic [1:0] err_inc;

    assign tx_beat      = tx_valid & tx_ready;
    assign rx_beat      = rx_valid & rx_ready;
    assign tx_pkt       = tx_beat & tx_eop;
    assign rx_pkt       = rx_beat & rx_eop;
    // A cycle with both a TX and an RX beat is still one active cycle.
    assign active_cycle = tx_beat | rx_beat;
    // Both strobes in one cycle are two distinct errors.
    assign err_inc      = {1'b0, err_corr} + {1'b0, err_uncorr};

    function automatic logic [31:0] sat_add(input logic [31:0] base,
                                            input logic [1:0]  inc);
        logic [32:0] sum;
        sum = {1'b0, base} + {31'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    // -----------------------------------------------------------------------
    // Link status and uptime
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_up     <= 1'b0;
            link_uptime <= 32'd0;
        end else begin
            link_up <= link_up_in;
            if (!link_up_in) begin
                link_uptime <= 32'd0;
            end else if (link_uptime != 32'hFFFF_FFFF) begin
                link_uptime <= link_uptime + 32'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Cumulative packet/error counters. A clear in the same cycle as an
    // increment leaves the counter at zero.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            packet_count_tx         <= 32'd0;
            packet_count_rx         <= 32'd0;
            error_count_total       <= 32'd0;
            error_count_correctable <= 32'd0;
        end else if (stats_clear) begin
            packet_count_tx         <= 32'd0;
            packet_count_rx         <= 32'd0;
            error_count_total       <= 32'd0;
            error_count_correctable <= 32'd0;
        end else begin
            packet_count_tx         <= sat_add(packet_count_tx, {1'b0, tx_pkt});
            packet_count_rx         <= sat_add(packet_count_rx, {1'b0, rx_pkt});
            error_count_total       <= sat_add(error_count_total, err_inc);
            error_count_correctable <= sat_add(error_count_correctable, {1'b0, err_corr});
        end
    end

    // -----------------------------------------------------------------------
    // Window accumulators and FSM
    // -----------------------------------------------------------------------
    state_t                 state_reg;
    state_t                 state_next;
    logic [WINDOW_LOG2-1:0] win_cnt_reg;
    logic [WINDOW_LOG2-1:0] win_cnt_next;
    logic [WINDOW_LOG2:0]   act_acc_reg;
    logic [WINDOW_LOG2:0]   act_acc_next;
    logic [15:0]            wgt_acc_reg;
    logic [15:0]            wgt_acc_next;
    logic [31:0]            bw_next;
    logic [7:0]             quality_next;
    logic                   valid_next;

    logic                   win_last;
    logic [WINDOW_LOG2:0]   act_sum;
    logic [16:0]            wgt_inc;
    logic [17:0]            wgt_sum;
    logic [15:0]            wgt_sat;
    logic [7:0]             quality_calc;

    assign win_last = (win_cnt_reg == CNT_LAST);

    // Sums include the current cycle so the boundary cycle's own events are
    // part of the window that closes on it. In IDLE the accumulators are 0,
    // so the same sums seed the first window cycle on link-up.
    assign act_sum = act_acc_reg + {{WINDOW_LOG2{1'b0}}, active_cycle};
    assign wgt_inc = {16'd0, err_corr} + (err_uncorr ? UNCORR_INC : 17'd0);
    assign wgt_sum = {2'b00, wgt_acc_reg} + {1'b0, wgt_inc};
    assign wgt_sat = (wgt_sum[17:16] != 2'b00) ? 16'hFFFF : wgt_sum[15:0];

    assign quality_calc = (wgt_sat >= 16'd255) ? 8'd0 : (8'hFF - wgt_sat[7:0]);

    always_comb begin
        state_next   = state_reg;
        win_cnt_next = win_cnt_reg;
        act_acc_next = act_acc_reg;
        wgt_acc_next = wgt_acc_reg;
        bw_next      = bandwidth_utilization;
        quality_next = link_quality;
        valid_next   = stats_valid;

        case (state_reg)
            ST_IDLE: begin
                bw_next      = 32'd0;
                quality_next = 8'd0;
                valid_next   = 1'b0;
                if (link_up_in) begin
                    // The cycle that first samples link-up is window cycle 0.
                    state_next   = ST_WARMUP;
                    win_cnt_next = CNT_ONE;
                    act_acc_next = act_sum;
                    wgt_acc_next = wgt_sat;
                end else begin
                    win_cnt_next = CNT_ZERO;
                    act_acc_next = '0;
                    wgt_acc_next = 16'd0;
                end
            end

            ST_WARMUP, ST_ACTIVE: begin
                if (!link_up_in) begin
                    // Partial window is dropped; metrics become unknown.
                    state_next   = ST_IDLE;
                    win_cnt_next = CNT_ZERO;
                    act_acc_next = '0;
                    wgt_acc_next = 16'd0;
                    bw_next      = 32'd0;
                    quality_next = 8'd0;
                    valid_next   = 1'b0;
                end else if (win_last) begin
                    state_next   = ST_ACTIVE;
                    win_cnt_next = CNT_ZERO;
                    act_acc_next = '0;
                    wgt_acc_next = 16'd0;
                    bw_next      = {{(31 - WINDOW_LOG2){1'b0}}, act_sum};
                    quality_next = quality_calc;
                    valid_next   = 1'b1;
                end else begin
                    win_cnt_next = win_cnt_reg + CNT_ONE;
                    act_acc_next = act_sum;
                    wgt_acc_next = wgt_sat;
                end
            end

            default: begin
                state_next   = ST_IDLE;
                win_cnt_next = CNT_ZERO;
                act_acc_next = '0;
                wgt_acc_next = 16'd0;
                bw_next      = 32'd0;
                quality_next = 8'd0;
                valid_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg             <= ST_IDLE;
            win_cnt_reg           <= CNT_ZERO;
            act_acc_reg           <= '0;
            wgt_acc_reg           <= 16'd0;
            bandwidth_utilization <= 32'd0;
            link_quality          <= 8'd0;
            stats_valid           <= 1'b0;
        end else begin
            state_reg             <= state_next;
            win_cnt_reg           <= win_cnt_next;
            act_acc_reg           <= act_acc_next;
            wgt_acc_reg           <= wgt_acc_next;
            bandwidth_utilization <= bw_next;
            link_quality          <= quality_next;
            stats_valid           <= valid_next;
        end
    end

endmodule

// File: tb/tb_ucie_link_stats_collector.sv
// ---------------------------------------------------------------------------
// tb_ucie_link_stats_collector
//
// Scoreboard-driven bench for ucie_link_stats_collector with a 16-cycle
// window. Each scenario task pushes (cycle, output, expected value) entries
// as it lays out its stimulus; after each clock the entries due at that
// cycle are popped and compared against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_ucie_link_stats_collector;

    logic        clk;
    logic        rst_n;
    logic        link_up_in;
    logic        tx_valid, tx_ready, tx_eop;
    logic        rx_valid, rx_ready, rx_eop;
    logic        err_corr, err_uncorr;
    logic        stats_clear;
    logic        link_up;
    logic [31:0] link_uptime;
    logic [31:0] packet_count_tx;
    logic [31:0] packet_count_rx;
    logic [31:0] error_count_total;
    logic [31:0] error_count_correctable;
    logic [31:0] bandwidth_utilization;
    logic [7:0]  link_quality;
    logic        stats_valid;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int O_LINK_UP = 0;
    localparam int O_UPTIME  = 1;
    localparam int O_TX      = 2;
    localparam int O_RX      = 3;
    localparam int O_ERR_TOT = 4;
    localparam int O_ERR_COR = 5;
    localparam int O_BW      = 6;
    localparam int O_QUAL    = 7;
    localparam int O_VALID   = 8;

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] exp;
        string       name;
    } sb_entry_t;

    sb_entry_t sb[$];

    ucie_link_stats_collector #(
        .WINDOW_LOG2   (4),
        .UNCORR_WEIGHT (16)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .link_up_in              (link_up_in),
        .tx_valid                (tx_valid),
        .tx_ready                (tx_ready),
        .tx_eop                  (tx_eop),
        .rx_valid                (rx_valid),
        .rx_ready                (rx_ready),
        .rx_eop                  (rx_eop),
        .err_corr                (err_corr),
        .err_uncorr              (err_uncorr),
        .stats_clear             (stats_clear),
        .link_up                 (link_up),
        .link_uptime             (link_uptime),
        .packet_count_tx         (packet_count_tx),
        .packet_count_rx         (packet_count_rx),
        .error_count_total       (error_count_total),
        .error_count_correctable (error_count_correctable),
        .bandwidth_utilization   (bandwidth_utilization),
        .link_quality            (link_quality),
        .stats_valid             (stats_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int id);
        case (id)
            O_LINK_UP: return {31'd0, link_up};
            O_UPTIME:  return link_uptime;
            O_TX:      return packet_count_tx;
            O_RX:      return packet_count_rx;
            O_ERR_TOT: return error_count_total;
            O_ERR_COR: return error_count_correctable;
            O_BW:      return bandwidth_utilization;
            O_QUAL:    return {24'd0, link_quality};
            O_VALID:   return {31'd0, stats_valid};
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_at(input int cyc, input int id, input logic [31:0] exp,
                             input string name);
        sb.push_back('{cyc, id, exp, name});
    endtask

    // Inputs change on the falling edge; outputs are read there too, i.e.
    // half a period after the rising edge that produced them.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        tx_valid    = 1'b0; tx_ready = 1'b0; tx_eop = 1'b0;
        rx_valid    = 1'b0; rx_ready = 1'b0; rx_eop = 1'b0;
        err_corr    = 1'b0; err_uncorr = 1'b0;
        stats_clear = 1'b0;
    endtask

    task automatic test_reset();
        sb_entry_t   e;
        logic [31:0] obs;
        rst_n      = 1'b0;
        link_up_in = 1'b0;
        idle_inputs();
        for (int id = 0; id <= 8; id++) expect_at(3, id, 32'd0, "reset_out");
        for (int c = 1; c <= 3; c++) begin
            step();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front(); obs = observe(e.id); n_tests++;
                if (obs !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s[%0d] c%0d: got 0x%08h expected 0x%08h", e.name, e.id, c, obs, e.exp);
                end else $display("[TB] %s[%0d] c%0d = 0x%08h", e.name, e.id, c, obs);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_warmup();
        sb_entry_t   e;
        logic [31:0] obs;
        link_up_in = 1'b1;
        expect_at(1,  O_LINK_UP, 32'd1,  "warm_link_up");
        expect_at(1,  O_UPTIME,  32'd1,  "warm_uptime1");
        expect_at(15, O_VALID,   32'd0,  "warm_valid_early");
        expect_at(15, O_QUAL,    32'd0,  "warm_qual_early");
        expect_at(15, O_UPTIME,  32'd15, "warm_uptime15");
        expect_at(16, O_VALID,   32'd1,  "warm_valid");
        expect_at(16, O_QUAL,    32'd255,"warm_quality");
        expect_at(16, O_BW,      32'd0,  "warm_bw");
        expect_at(16, O_UPTIME,  32'd16, "warm_uptime16");
        for (int c = 1; c <= 16; c++) begin
            step();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front(); obs = observe(e.id); n_tests++;
                if (obs !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s c%0d: got 0x%08h expected 0x%08h", e.name, c, obs, e.exp);
                end else $display("[TB] %s c%0d = 0x%08h", e.name, c, obs);
            end
        end
    endtask

    task automatic test_traffic();
        sb_entry_t   e;
        logic [31:0] obs;
        expect_at(3,  O_TX,     32'd1,   "trf_tx_latency");
        expect_at(15, O_BW,     32'd0,   "trf_bw_held");
        expect_at(15, O_VALID,  32'd1,   "trf_valid_held");
        expect_at(16, O_TX,     32'd3,   "trf_tx_pkts");
        expect_at(16, O_RX,     32'd2,   "trf_rx_pkts");
        expect_at(16, O_BW,     32'd12,  "trf_bw");
        expect_at(16, O_QUAL,   32'd255, "trf_quality");
        expect_at(16, O_UPTIME, 32'd32,  "trf_uptime");
        for (int c = 1; c <= 16; c++) begin
            int i = c - 1;
            // TX beats on cycles 0..9 (EOP 2,5,9); RX beats 8..11 (EOP 10,11),
            // overlapping TX on 8,9. Cycles 12/13 are non-handshakes with EOP.
            tx_valid = (i <= 9) || (i == 12);
            tx_ready = (i <= 9);
            tx_eop   = (i == 2) || (i == 5) || (i == 9) || (i == 12);
            rx_valid = (i >= 8) && (i <= 11);
            rx_ready = ((i >= 8) && (i <= 11)) || (i == 13);
            rx_eop   = (i == 10) || (i == 11) || (i == 13);
            step();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front(); obs = observe(e.id); n_tests++;
                if (obs !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s c%0d: got 0x%08h expected 0x%08h", e.name, c, obs, e.exp);
                end else $display("[TB] %s c%0d = 0x%08h", e.name, c, obs);
            end
        end
        idle_inputs();
    endtask

    task automatic test_errors();
        sb_entry_t   e;
        logic [31:0] obs;
        expect_at(1,  O_ERR_COR, 32'd1,   "err_corr_latency");
        expect_at(1,  O_ERR_TOT, 32'd1,   "err_tot_latency");
        expect_at(4,  O_ERR_COR, 32'd4,   "err_corr_cnt");
        expect_at(4,  O_ERR_TOT, 32'd5,   "err_tot_cnt");
        expect_at(16, O_QUAL,    32'd235, "err_quality");
        expect_at(16, O_BW,      32'd0,   "err_bw");
        expect_at(16, O_TX,      32'd3,   "err_tx_kept");
        for (int c = 1; c <= 16; c++) begin
            int i = c - 1;
            err_corr   = (i <= 3);
            err_uncorr = (i == 3);
            step();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front(); obs = observe(e.id); n_tests++;
                if (obs !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s c%0d: got 0x%08h expected 0x%08h", e.name, c, obs, e.exp);
                end else $display("[TB] %s c%0d = 0x%08h", e.name, c, obs);
            end
        end
        idle_inputs();
    endtask

    task automatic test_uncorr();
        sb_entry_t   e;
        logic [31:0] obs;
        expect_at(16, O_QUAL,    32'd0,   "unc_quality_zero");
        expect_at(16, O_ERR_TOT, 32'd21,  "unc_err_tot");
        expect_at(16, O_ERR_COR, 32'd4,   "unc_err_corr");
        expect_at(16, O_VALID,   32'd1,   "unc_valid");
        expect_at(31, O_QUAL,    32'd0,   "unc_quality_held");
        expect_at(32, O_QUAL,    32'd255, "unc_quality_recover");
        for (int c = 1; c <= 32; c++) begin
            err_uncorr = (c <= 16);
            step();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front(); obs = observe(e.id); n_tests++;
                if (obs !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s c%0d: got 0x%08h expected 0x%08h", e.name, c, obs, e.exp);
                end else $display("[TB] %s c%0d = 0x%08h", e.name, c, obs);
            end
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        sb_entry_t   e;
        logic [31:0] obs;
        // Preload the TX counter just below saturation.
        force dut.packet_count_tx = 32'hFFFF_FFFD;
        #1;
        release dut.packet_count_tx;
        expect_at(1, O_TX,      32'hFFFF_FFFE, "sat_tx_1");
        expect_at(2, O_TX,      32'hFFFF_FFFF, "sat_tx_2");
        expect_at(3, O_TX,      32'hFFFF_FFFF, "sat_tx_hold");
        expect_at(4, O_TX,      32'd0,         "clr_tx");
        expect_at(4, O_RX,      32'd0,         "clr_rx");
        expect_at(4, O_ERR_TOT, 32'd0,         "clr_err_tot");
        expect_at(4, O_ERR_COR, 32'd0,         "clr_err_corr");
        expect_at(4, O_UPTIME,  32'd84,        "clr_uptime_kept");
        expect_at(4, O_VALID,   32'd1,         "clr_valid_kept");
        expect_at(5, O_TX,      32'd0,         "clr_tx_after");
        for (int c = 1; c <= 5; c++) begin
            int i = c - 1;
            tx_valid    = (i <= 3);
            tx_ready    = (i <= 3);
            tx_eop      = (i <= 3);
            rx_valid    = (i == 3);
            rx_ready    = (i == 3);
            rx_eop      = (i == 3);
            err_corr    = (i == 3);
            stats_clear = (i == 3);
            step();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front(); obs = observe(e.id); n_tests++;
                if (obs !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s c%0d: got 0x%08h expected 0x%08h", e.name, c, obs, e.exp);
                end else $display("[TB] %s c%0d = 0x%08h", e.name, c, obs);
            end
        end
        idle_inputs();
    endtask

    task automatic test_link_drop();
        sb_entry_t   e;
        logic [31:0] obs;
        expect_at(2,  O_TX,      32'd1,   "drop_tx_before");
        expect_at(2,  O_ERR_COR, 32'd1,   "drop_corr_before");
        expect_at(2,  O_VALID,   32'd1,   "drop_valid_before");
        expect_at(3,  O_UPTIME,  32'd0,   "drop_uptime");
        expect_at(3,  O_LINK_UP, 32'd0,   "drop_link_up");
        expect_at(3,  O_VALID,   32'd0,   "drop_valid");
        expect_at(3,  O_QUAL,    32'd0,   "drop_quality");
        expect_at(3,  O_BW,      32'd0,   "drop_bw");
        expect_at(3,  O_TX,      32'd1,   "drop_tx_kept");
        expect_at(3,  O_ERR_TOT, 32'd1,   "drop_err_kept");
        expect_at(4,  O_LINK_UP, 32'd1,   "rearm_link_up");
        expect_at(4,  O_UPTIME,  32'd1,   "rearm_uptime1");
        expect_at(18, O_VALID,   32'd0,   "rearm_valid_early");
        expect_at(18, O_UPTIME,  32'd15,  "rearm_uptime15");
        expect_at(19, O_VALID,   32'd1,   "rearm_valid");
        expect_at(19, O_QUAL,    32'd255, "rearm_quality");
        expect_at(19, O_BW,      32'd0,   "rearm_bw");
        expect_at(19, O_UPTIME,  32'd16,  "rearm_uptime16");
        expect_at(19, O_TX,      32'd1,   "rearm_tx_kept");
        for (int c = 1; c <= 19; c++) begin
            int i = c - 1;
            // Traffic and an error land in the partial window that the drop
            // discards, so the next window must report a clean link.
            link_up_in = (i != 2);
            tx_valid   = (i == 0);
            tx_ready   = (i == 0);
            tx_eop     = (i == 0);
            err_corr   = (i == 1);
            step();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front(); obs = observe(e.id); n_tests++;
                if (obs !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s c%0d: got 0x%08h expected 0x%08h", e.name, c, obs, e.exp);
                end else $display("[TB] %s c%0d = 0x%08h", e.name, c, obs);
            end
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back_reset();
        sb_entry_t   e;
        logic [31:0] obs;
        for (int c = 1; c <= 5; c++) begin
            tx_valid = 1'b1; tx_ready = 1'b1; tx_eop = 1'b1;
            step();
        end
        idle_inputs();
        // Reset lands between clock edges; outputs must clear without a clock.
        expect_at(99, O_UPTIME, 32'd0, "areset_uptime");
        expect_at(99, O_TX,     32'd0, "areset_tx");
        expect_at(99, O_VALID,  32'd0, "areset_valid");
        expect_at(99, O_LINK_UP,32'd0, "areset_link_up");
        #2;
        rst_n = 1'b0;
        #1;
        while (sb.size() > 0 && sb[0].cyc == 99) begin
            e = sb.pop_front(); obs = observe(e.id); n_tests++;
            if (obs !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, obs, e.exp);
            end else $display("[TB] %s = 0x%08h", e.name, obs);
        end
        @(negedge clk);
        link_up_in = 1'b0;
        rst_n      = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_traffic();
        test_errors();
        test_uncorr();
        test_saturation();
        test_link_drop();
        test_back_to_back_reset();
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
